id_ex_reg: RTL
==============

# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core. It captures the decode-stage bundle at each rising edge and presents it to the execute stage one cycle later: instruction word, PC, register-file read data, the 32-bit extended immediate produced by the sign/zero-extension unit, write-back target, exception code and branch-delay flag. It implements bubble insertion on hazard stall and whole-stage flush on exception/`eret`. It also decrements the decode-stage Tnew so the hazard unit sees a correct EX-stage Tnew.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset and on flush

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- stall  input  1  hazard unit; the ID stage holds, EX receives a bubble
- flush  input  1  CP0 exception/eret; clear the stage
- instr_d  input  32  decoded instruction word
- pc_d  input  32  PC of the ID instruction
- rs_data_d  input  32  forwarded rs value
- rt_data_d  input  32  forwarded rt value
- ext_d  input  32  extended immediate from the extension unit
- a3_d  input  5  GPR write target (0 = no write)
- tnew_d  input  2  cycles until the result is ready, measured at ID
- exc_code_d  input  5  pending exception code (0 = none)
- bd_d  input  1  the ID instruction is in a branch delay slot
- instr_e, pc_e, rs_data_e, rt_data_e, ext_e  output  32 each  registered copies
- a3_e  output  5
- tnew_e  output  2
- exc_code_e  output  5
- bd_e  output  1

## Operation
- All outputs are registers updated only on the rising edge of clk. Priority is reset > flush > stall > normal.
- **reset**
  - pc_e = RESET_PC.
  - All other outputs = 0: instr_e = 32'h0 (nop), a3_e = 0, tnew_e = 0, exc_code_e = 0, bd_e = 0.
- **flush**: same values as reset. bd_e = 0 and pc_e = RESET_PC.
- **stall** (bubble):
  - instr_e, rs_data_e, rt_data_e, ext_e, a3_e, tnew_e and exc_code_e are cleared to 0.
  - pc_e = pc_d and bd_e = bd_d, so CP0 records the correct EPC/BD if an interrupt lands on the bubble.
- **normal**:
  - Every field is copied from its _d input.
  - tnew_e = (tnew_d == 0) ? 0 : tnew_d − 1. It saturates at 0 and never wraps to 2'b11.
- A bubble must never write the register file or raise an exception. a3_e = 0 and exc_code_e = 0 guarantee this.
- ext_d is latched as given: no re-extension, no width change.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Outputs hold between edges and have no combinational path from inputs to outputs.
- stall held for K cycles produces K consecutive bubbles. The first real instruction appears the cycle after stall falls.
- flush and stall asserted together: flush wins, and pc_e = RESET_PC.
- reset asserted mid-stream: the next edge gives reset values regardless of stall or flush. The first edge after reset deasserts captures the _d inputs normally.
- Asynchronous reset behaviour is not permitted.

## Structure
- Shared constants file/package holds RESET_PC (32'h0000_3000), EXC_NONE (5'd0), NOP_INSTR (32'h0) and the Tnew width (2). The same package is used by the IF/ID, EX/MEM and MEM/WB registers and the hazard unit.
- One natural sub-module, `pipe_field`:
  - Parameters WIDTH and RST_VAL.
  - Inputs clk, reset, clr, d; output q.
  - Instantiated once per field.
  - pc_e and bd_e instances tie clr to flush only. All other fields tie clr to flush|stall.
- The Tnew decrement is a single saturating expression ahead of its pipe_field.

## Test plan
- **Reset**: assert reset with all _d inputs = 32'hFFFF_FFFF → pc_e = 32'h0000_3000; every other output = 0.
- **Pass-through**: instr_d = 32'h3C01_1234, ext_d = 32'hFFFF_8000, pc_d = 32'h0000_3004, a3_d = 1, tnew_d = 2 → after one edge the outputs match, with tnew_e = 1.
- **Tnew saturation**: tnew_d = 0 → tnew_e = 0. tnew_d = 1 → tnew_e = 0.
- **Stall bubble**: pc_d = 32'h0000_3010, bd_d = 1, stall = 1 for 2 cycles:
  - Both cycles give instr_e = 0, a3_e = 0, exc_code_e = 0, pc_e = 32'h0000_3010, bd_e = 1.
  - The cycle after stall falls gives the real instruction.
- **Flush vs stall**: flush = 1 and stall = 1 with exc_code_d = 5'd10 → pc_e = 32'h0000_3000, exc_code_e = 0, bd_e = 0.
- **Reset mid-stream**: reset asserted while a non-zero bundle is flowing → next edge gives reset values. Deasserting reset → next edge captures the new inputs.

Source files
------------

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline constants and helpers for the pipeline registers and the hazard unit.
package id_ex_reg_pkg;

  localparam int          TNEW_W    = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef logic [TNEW_W-1:0] tnew_t;

  // One stage closer to the result; an already-ready value stays ready.
  function automatic tnew_t tnew_dec(input tnew_t t);
    return (t == '0) ? '0 : t - tnew_t'(1);
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-side bundle, execute-side bundle and the hazard/CP0 controls of the ID/EX register.
interface id_ex_reg_if;
  import id_ex_reg_pkg::*;

  logic        stall;
  logic        flush;

  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] rs_data_d;
  logic [31:0] rt_data_d;
  logic [31:0] ext_d;
  logic [4:0]  a3_d;
  tnew_t       tnew_d;
  logic [4:0]  exc_code_d;
  logic        bd_d;

  logic [31:0] instr_e;
  logic [31:0] pc_e;
  logic [31:0] rs_data_e;
  logic [31:0] rt_data_e;
  logic [31:0] ext_e;
  logic [4:0]  a3_e;
  tnew_t       tnew_e;
  logic [4:0]  exc_code_e;
  logic        bd_e;

  modport master (
    output stall, flush,
    output instr_d, pc_d, rs_data_d, rt_data_d, ext_d, a3_d, tnew_d, exc_code_d, bd_d,
    input  instr_e, pc_e, rs_data_e, rt_data_e, ext_e, a3_e, tnew_e, exc_code_e, bd_e
  );

  modport slave (
    input  stall, flush,
    input  instr_d, pc_d, rs_data_d, rt_data_d, ext_d, a3_d, tnew_d, exc_code_d, bd_d,
    output instr_e, pc_e, rs_data_e, rt_data_e, ext_e, a3_e, tnew_e, exc_code_e, bd_e
  );

endinterface

// File: rtl/id_ex_reg_pipe_field.sv
// One field of a pipeline register: synchronous reset, clear-to-reset-value, else capture.
module pipe_field #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) q <= RST_VAL;
    else              q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: bubble on stall, full clear on flush, Tnew aged by one stage.
module id_ex_reg #(
  parameter logic [31:0] RESET_PC = id_ex_reg_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  id_ex_reg_if.slave  bus
);
  import id_ex_reg_pkg::*;

  logic  clr_all;
  tnew_t tnew_nxt;

  assign clr_all  = bus.flush | bus.stall;
  assign tnew_nxt = tnew_dec(bus.tnew_d);

  pipe_field #(.WIDTH(32), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset(reset), .clr(clr_all), .d(bus.instr_d), .q(bus.instr_e));

  // PC and BD survive a bubble so an interrupt taken on it still reports the right EPC/BD.
  pipe_field #(.WIDTH(32), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .clr(bus.flush), .d(bus.pc_d), .q(bus.pc_e));

  pipe_field #(.WIDTH(1), .RST_VAL(1'b0)) u_bd (
    .clk(clk), .reset(reset), .clr(bus.flush), .d(bus.bd_d), .q(bus.bd_e));

  pipe_field #(.WIDTH(32), .RST_VAL(32'h0)) u_rs_data (
    .clk(clk), .reset(reset), .clr(clr_all), .d(bus.rs_data_d), .q(bus.rs_data_e));

  pipe_field #(.WIDTH(32), .RST_VAL(32'h0)) u_rt_data (
    .clk(clk), .reset(reset), .clr(clr_all), .d(bus.rt_data_d), .q(bus.rt_data_e));

  pipe_field #(.WIDTH(32), .RST_VAL(32'h0)) u_ext (
    .clk(clk), .reset(reset), .clr(clr_all), .d(bus.ext_d), .q(bus.ext_e));

  pipe_field #(.WIDTH(5), .RST_VAL(5'd0)) u_a3 (
    .clk(clk), .reset(reset), .clr(clr_all), .d(bus.a3_d), .q(bus.a3_e));

  pipe_field #(.WIDTH(TNEW_W), .RST_VAL('0)) u_tnew (
    .clk(clk), .reset(reset), .clr(clr_all), .d(tnew_nxt), .q(bus.tnew_e));

  pipe_field #(.WIDTH(5), .RST_VAL(EXC_NONE)) u_exc_code (
    .clk(clk), .reset(reset), .clr(clr_all), .d(bus.exc_code_d), .q(bus.exc_code_e));

endmodule
